l_next_port: RTL
================

# l_next_port

Downstream stage of the cache: consumes the cache's next-level bus (`cmd_out`/`add_out`) and models the next memory level. It buffers transactions in a small FIFO and services them one at a time with a fixed access latency. It emits one completion pulse per transaction and keeps per-command statistics. It also reports when all traffic has drained after the trace driver raises `done`.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `LATENCY`, 3: access cycles per transaction; ≥1.
- `CNT_W`, 16: width of each statistics counter.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `cmd_in`  in  2  bus command from the cache: 00 NOP, 01 READ, 10 WRITE, 11 RFO (read-for-ownership).
- `add_in`  in  26  line address accompanying `cmd_in`.
- `done`  in  1  end-of-trace indication from the stimulus driver; level.
- `mem_valid`  out  1  one-cycle completion pulse.
- `mem_cmd`  out  2  command of the completing transaction; valid while `mem_valid`.
- `mem_addr`  out  26  address of the completing transaction; valid while `mem_valid`.
- `full`  out  1  FIFO occupancy == `DEPTH`.
- `busy`  out  1  FSM not IDLE, or FIFO non-empty.
- `read_count`, `write_count`, `rfo_count`  out  `CNT_W`  completed transactions per command.
- `drop_count`  out  `CNT_W`  non-NOP commands discarded because the FIFO was full.
- `drained`  out  1  `done` seen, FIFO empty, FSM IDLE.

## Operation
- **Reset:** while `rst` is high at an edge, the block clears all state.
  - FIFO pointers and occupancy clear; FSM goes to IDLE.
  - All counters go to 0; the sticky done flag clears.
  - `mem_valid`=0, `mem_cmd`=0, `mem_addr`=0, `full`=0, `busy`=0, `drained`=0.
  - A reset mid-transaction discards the in-flight entry and all queued entries; no `mem_valid` is produced for them.
- **Enqueue:** each edge where `cmd_in`≠00, the block handles the command by registered occupancy *before* the edge.
  - If occupancy < `DEPTH`: write {`cmd_in`,`add_in`} at the tail.
  - If occupancy == `DEPTH`: discard the command and increment `drop_count`. This holds even if a pop happens on the same edge.
- A push and a pop on the same edge leave occupancy unchanged.
- NOP is never enqueued and never counted.
- **FSM states:** IDLE, BUSY, RESP.
  - IDLE: if registered occupancy > 0, pop the head into service registers, load `wait_cnt` = `LATENCY`-1, and go to BUSY. An entry pushed on the same edge is not visible until the next edge.
  - BUSY: if `wait_cnt` ≠ 0, decrement it; else go to RESP.
    - On entry to RESP: drive `mem_cmd`/`mem_addr` from the service registers.
    - On entry to RESP: increment the counter matching the command.
  - RESP: `mem_valid`=1 for exactly this cycle; the next edge returns unconditionally to IDLE.
- **Counters:** saturate at all-ones; they never wrap.
- **`mem_cmd`/`mem_addr`:** hold their last value outside RESP.
- **`done`:** sampled into a sticky flag. Commands arriving after `done` are still accepted.
- **`drained`:** registered. It is 1 when the sticky flag is set, occupancy is 0 and the FSM is IDLE. It drops back to 0 if a new command is enqueued.

## Timing
- Command sampled at edge k, with FIFO empty and FSM IDLE:
  - pop at edge k+1;
  - RESP entered at edge k+1+`LATENCY`;
  - `mem_valid` high from edge k+1+`LATENCY` to edge k+2+`LATENCY`.
  - With the defaults, `mem_valid` is high between edges k+4 and k+5.
- Sustained throughput is one transaction per `LATENCY`+2 cycles.
- Completions leave in FIFO (arrival) order.
- `full`, `busy` and `drained` are registered and reflect state after the latest edge.
- `busy`=1 during the cycle the FSM is in RESP.

## Test plan
- **Single READ:** reset, then `cmd_in`=01, `add_in`=26'h0ABCDEF at edge 0, then NOPs → `mem_valid` high only between edges 4–5, with `mem_cmd`=01 and `mem_addr`=26'h0ABCDEF. Afterwards `read_count`=1 and all other counters are 0.
- **Ordering and throughput:** WRITE 0x10, RFO 0x20, READ 0x30, WRITE 0x40 on consecutive edges 0–3 → four `mem_valid` pulses starting at edges 4, 9, 14 and 19, in that order. Afterwards `write_count`=2, `rfo_count`=1, `read_count`=1, `drop_count`=0.
- **Overflow:** 7 non-NOP commands on consecutive edges 0–6.
  - Edge 1: pop; `full` rises after edge 4.
  - Commands at edges 5 and 6 are dropped: `drop_count`=2.
  - 5 completions total.
- **Drain:** raise `done` during the overflow scenario → `drained` stays 0 until the cycle after the last RESP, then reads 1. A new READ then clears `drained`, and it re-asserts after that READ completes.
- **Reset mid-operation:** enqueue 3 commands, assert `rst` for one edge while in BUSY.
  - All outputs read 0 after that edge.
  - No `mem_valid` for the flushed entries.
  - A following READ completes with the normal k+4 timing.
- **Saturation:** with `CNT_W`=2, issue 5 READs with gaps ≥5 cycles → `read_count` stops at 3; with `CNT_W`=2 and 10 back-to-back commands, `drop_count` stops at 3.

Source files
------------

// File: rtl/l_next_port.sv
// l_next_port: next-level memory model behind the cache.
// Queues incoming bus commands in a small FIFO, services them one at a time
// with a fixed access latency, emits a one-cycle completion pulse per
// transaction, keeps saturating per-command statistics and reports when all
// traffic has drained after the trace driver signals done.
module l_next_port #(
  parameter int DEPTH   = 4,   // FIFO entries, power of two, >= 2
  parameter int LATENCY = 3,   // access cycles per transaction, >= 1
  parameter int CNT_W   = 16   // width of each statistics counter
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       cmd_in,
  input  logic [25:0]      add_in,
  input  logic             done,
  output logic             mem_valid,
  output logic [1:0]       mem_cmd,
  output logic [25:0]      mem_addr,
  output logic             full,
  output logic             busy,
  output logic [CNT_W-1:0] read_count,
  output logic [CNT_W-1:0] write_count,
  output logic [CNT_W-1:0] rfo_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             drained
);

  // Bus command encoding from the cache.
  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_READ  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_RFO   = 2'b11
  } cmd_t;

  // Service FSM: wait for work, count out the access, present the result.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_RESP = 2'b10
  } state_t;

  // One queued transaction.
  typedef struct packed {
    logic [1:0]  cmd;
    logic [25:0] addr;
  } entry_t;

  localparam int AW = $clog2(DEPTH);              // pointer width
  localparam int CW = AW + 1;                     // occupancy width (0..DEPTH)
  localparam int WW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] LP_DEPTH     = CW'(DEPTH);
  localparam logic [WW-1:0] LP_WAIT_LOAD = WW'(LATENCY - 1);

  // FIFO storage and bookkeeping
  entry_t         r_fifo [DEPTH];
  logic [AW-1:0]  r_head;
  logic [AW-1:0]  r_tail;
  logic [CW-1:0]  r_count;
  logic [CW-1:0]  w_count_nxt;
  entry_t         w_entry_in;

  // Service side
  state_t         r_state;
  state_t         w_state_nxt;
  logic [WW-1:0]  r_wait_cnt;
  logic [WW-1:0]  w_wait_nxt;
  entry_t         r_svc;

  // Handshake decodes
  logic           w_cmd_valid;
  logic           w_push;
  logic           w_drop;
  logic           w_pop;
  logic           w_resp_entry;

  // Completion bus and statistics
  logic [1:0]       r_mem_cmd;
  logic [25:0]      r_mem_addr;
  logic [CNT_W-1:0] r_read_cnt;
  logic [CNT_W-1:0] r_write_cnt;
  logic [CNT_W-1:0] r_rfo_cnt;
  logic [CNT_W-1:0] r_drop_cnt;

  // Status
  logic           r_done;
  logic           w_done_nxt;
  logic           r_full;
  logic           r_busy;
  logic           r_drained;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Enqueue decisions use the occupancy registered before the edge, so a
  // command arriving at a full FIFO is dropped even if a pop happens on the
  // same edge.
  // ---------------------------------------------------------------------------
  assign w_cmd_valid = (cmd_in != CMD_NOP);
  assign w_push      = w_cmd_valid && (r_count != LP_DEPTH);
  assign w_drop      = w_cmd_valid && (r_count == LP_DEPTH);
  assign w_entry_in  = {cmd_in, add_in};
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
  assign w_done_nxt  = r_done | done;

  // Next-state and pop/response decode for the service FSM.
  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    w_state_nxt  = r_state;
    w_wait_nxt   = r_wait_cnt;
    w_pop        = 1'b0;
    w_resp_entry = 1'b0;
    mem_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Only entries visible in the registered occupancy can be taken;
        // a push on this same edge is picked up one edge later.
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_wait_nxt  = LP_WAIT_LOAD;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_wait_cnt != '0) begin
          w_wait_nxt = r_wait_cnt - WW'(1);
        end else begin
          w_state_nxt  = S_RESP;
          w_resp_entry = 1'b1;
        end
      end
      S_RESP: begin
        mem_valid   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Service FSM state and latency counter.
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // FIFO payload write at the tail.
  // NOTE: the payload array is deliberately not reset; the pointers and
  // occupancy define which entries are valid, so stale data is never read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_tail] <= w_entry_in;
    end
  end

  // FIFO pointers and occupancy; reset discards everything queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + AW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + AW'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  // Capture the head entry into the service registers on pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_svc <= '0;
    end else if (w_pop) begin
      r_svc <= r_fifo[r_head];
    end
  end

  // Completion bus: loaded on entry to RESP, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_cmd  <= '0;
      r_mem_addr <= '0;
    end else if (w_resp_entry) begin
      r_mem_cmd  <= r_svc.cmd;
      r_mem_addr <= r_svc.addr;
    end
  end

  // Per-command completion counters and the drop counter, all saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_read_cnt  <= '0;
      r_write_cnt <= '0;
      r_rfo_cnt   <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_resp_entry) begin
        case (r_svc.cmd)
          CMD_READ:  r_read_cnt  <= f_sat_inc(r_read_cnt);
          CMD_WRITE: r_write_cnt <= f_sat_inc(r_write_cnt);
          CMD_RFO:   r_rfo_cnt   <= f_sat_inc(r_rfo_cnt);
          default:   ;  // NOP is never enqueued
        endcase
      end
      if (w_drop) begin
        r_drop_cnt <= f_sat_inc(r_drop_cnt);
      end
    end
  end

  // Registered status flags computed from the post-edge state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done    <= 1'b0;
      r_full    <= 1'b0;
      r_busy    <= 1'b0;
      r_drained <= 1'b0;
    end else begin
      r_done    <= w_done_nxt;
      r_full    <= (w_count_nxt == LP_DEPTH);
      r_busy    <= (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
      r_drained <= w_done_nxt && (w_count_nxt == '0) && (w_state_nxt == S_IDLE);
    end
  end

  assign mem_cmd     = r_mem_cmd;
  assign mem_addr    = r_mem_addr;
  assign full        = r_full;
  assign busy        = r_busy;
  assign drained     = r_drained;
  assign read_count  = r_read_cnt;
  assign write_count = r_write_cnt;
  assign rfo_count   = r_rfo_cnt;
  assign drop_count  = r_drop_cnt;

endmodule
